// File: rtl/fwd_hazard_scoreboard_if.sv
// Operand/stage/long-op bundle between the ID/EX pipeline and the hazard unit.
// The pipeline side is the master; the hazard unit is the slave.
interface fwd_hazard_scoreboard_if #(
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 3,
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic [NUM_SRC*ADDR_W-1:0]    src_addr;
    logic [NUM_SRC-1:0]           src_valid;
    logic [ADDR_W-1:0]            dst_addr;
    logic                         dst_valid;
    logic [NUM_STAGES*ADDR_W-1:0] stage_rd;
    logic [NUM_STAGES-1:0]        stage_wr;
    logic [NUM_STAGES-1:0]        stage_rdy;
    logic                         lo_issue;
    logic                         lo_done;
    logic [ADDR_W-1:0]            lo_done_rd;
    logic                         cnt_clr;
    logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
    logic                         stall;
    logic [ADDR_W:0]              pend_count;
    logic [CNT_W-1:0]             stall_count;
    logic                         sb_err;

    modport master (
        output src_addr, src_valid, dst_addr, dst_valid, stage_rd, stage_wr, stage_rdy,
        output lo_issue, lo_done, lo_done_rd, cnt_clr,
        input  fwd_sel, stall, pend_count, stall_count, sb_err
    );

    modport slave (
        input  src_addr, src_valid, dst_addr, dst_valid, stage_rd, stage_wr, stage_rdy,
        input  lo_issue, lo_done, lo_done_rd, cnt_clr,
        output fwd_sel, stall, pend_count, stall_count, sb_err
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Bypass select, load-use/scoreboard stall and long-op scoreboard for the ID/EX boundary.
// fwd_sel/stall are zero-latency combinational; scoreboard, counters and sb_err update on the next edge.
module fwd_hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 3,
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 16
) (
    input logic                   clk,
    input logic                   arst_n,
    fwd_hazard_scoreboard_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);
    localparam int NREG  = 1 << ADDR_W;

    logic [NREG-1:0]          sb_q, sb_d;
    logic [ADDR_W:0]          pend_q, pend_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;

    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                     lu_haz;
    logic                     sb_haz;
    logic                     stall;
    logic [ADDR_W-1:0]        op_addr;
    logic                     found;

    logic                     set_en;
    logic                     clr_req;
    logic                     clr_en;
    logic                     same_reg;

    // Youngest matching stage wins even when it is not ready: that is a load-use stall,
    // never a fallback to an older stage.
    always_comb begin
        sel     = '0;
        lu_haz  = 1'b0;
        op_addr = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            op_addr = bus.src_addr[i*ADDR_W +: ADDR_W];
            found   = 1'b0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (!found && bus.src_valid[i] && bus.stage_wr[k] && (op_addr != '0) &&
                    (bus.stage_rd[k*ADDR_W +: ADDR_W] == op_addr)) begin
                    found                  = 1'b1;
                    sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    if (!bus.stage_rdy[k]) begin
                        lu_haz = 1'b1;
                    end
                end
            end
        end
    end

    // Registered view only: a bit cleared this cycle still stalls. Bit 0 is never set.
    always_comb begin
        sb_haz = bus.dst_valid && sb_q[bus.dst_addr];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.src_valid[i] && sb_q[bus.src_addr[i*ADDR_W +: ADDR_W]]) begin
                sb_haz = 1'b1;
            end
        end
    end

    assign stall = lu_haz | sb_haz;

    always_comb begin
        set_en   = bus.lo_issue && !stall && (bus.dst_addr != '0);
        clr_req  = bus.lo_done && (bus.lo_done_rd != '0);
        clr_en   = clr_req && sb_q[bus.lo_done_rd];
        same_reg = set_en && clr_en && (bus.dst_addr == bus.lo_done_rd);

        sb_d = sb_q;
        if (clr_en) begin
            sb_d[bus.lo_done_rd] = 1'b0;
        end
        if (set_en) begin
            sb_d[bus.dst_addr] = 1'b1;
        end

        // Same-register issue+done leaves the bit set, so neither side moves the count.
        pend_d = pend_q;
        if (set_en && !sb_q[bus.dst_addr]) begin
            pend_d = pend_d + (ADDR_W+1)'(1);
        end
        if (clr_en && !same_reg) begin
            pend_d = pend_d - (ADDR_W+1)'(1);
        end

        err_d = err_q | (clr_req && !sb_q[bus.lo_done_rd]);

        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sb_q   <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            sb_q   <= sb_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus.fwd_sel     = sel;
    assign bus.stall       = stall;
    assign bus.pend_count  = pend_q;
    assign bus.stall_count = cnt_q;
    assign bus.sb_err      = err_q;
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench: expectations are queued as each cycle is driven and drained at the following negedge.
module tb_fwd_hazard_scoreboard;
    localparam int ADDR_W     = 5;
    localparam int NUM_SRC    = 3;
    localparam int NUM_STAGES = 3;
    localparam int CNT_W      = 16;
    localparam int SEL_W      = 2;

    localparam int S_FWD  = 0;
    localparam int S_STL  = 1;
    localparam int S_PEND = 2;
    localparam int S_CNT  = 3;
    localparam int S_ERR  = 4;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic arst_n;

    fwd_hazard_scoreboard_if #(
        .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES), .CNT_W(CNT_W)
    ) bus ();

    fwd_hazard_scoreboard #(
        .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic        exp_stall;
    logic [31:0] exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_FWD:   return 32'(bus.fwd_sel);
            S_STL:   return 32'(bus.stall);
            S_PEND:  return 32'(bus.pend_count);
            S_CNT:   return 32'(bus.stall_count);
            default: return 32'(bus.sb_err);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // Check everything queued for this cycle, then advance the stall-counter model across the edge.
    task automatic tick(input string tag);
        exp_t e;
        @(negedge clk);
        expect_val({tag, "/stall"}, S_STL, 32'(exp_stall));
        expect_val({tag, "/stall_count"}, S_CNT, exp_cnt);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, observe(e.sig), e.val);
        end
        if (bus.cnt_clr) exp_cnt = 0;
        else if (exp_stall && exp_cnt != 32'hFFFF) exp_cnt = exp_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.src_addr   = '0;
        bus.src_valid  = '0;
        bus.dst_addr   = '0;
        bus.dst_valid  = 1'b0;
        bus.stage_rd   = '0;
        bus.stage_wr   = '0;
        bus.stage_rdy  = '0;
        bus.lo_issue   = 1'b0;
        bus.lo_done    = 1'b0;
        bus.lo_done_rd = '0;
        bus.cnt_clr    = 1'b0;
        exp_stall      = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [ADDR_W-1:0] a);
        bus.src_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_stage(input int k, input logic [ADDR_W-1:0] a);
        bus.stage_rd[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic load_use_setup();
        clear_inputs();
        set_stage(0, 5'd7);
        bus.stage_wr  = 3'b001;
        bus.stage_rdy = 3'b110;
        set_src(1, 5'd7);
        bus.src_valid = 3'b010;
        exp_stall     = 1'b1;
    endtask

    initial begin
        arst_n  = 1'b0;
        exp_cnt = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;

        expect_val("rst/fwd_sel", S_FWD, 0);
        expect_val("rst/pend", S_PEND, 0);
        expect_val("rst/sb_err", S_ERR, 0);
        tick("rst");

        // Youngest of two ready matches, then the older one alone
        clear_inputs();
        set_src(0, 5'd5);
        bus.src_valid = 3'b001;
        set_stage(0, 5'd5);
        set_stage(1, 5'd5);
        bus.stage_wr  = 3'b011;
        bus.stage_rdy = 3'b111;
        expect_val("fwd_young", S_FWD, 1);
        tick("fwd_young");
        bus.stage_wr = 3'b010;
        expect_val("fwd_older", S_FWD, 2);
        tick("fwd_older");

        // Operand 2 forwarded from stage 2
        clear_inputs();
        set_src(2, 5'd6);
        bus.src_valid = 3'b100;
        set_stage(2, 5'd6);
        bus.stage_wr  = 3'b100;
        bus.stage_rdy = 3'b111;
        expect_val("fwd_op2", S_FWD, 32'(3) << (2*SEL_W));
        tick("fwd_op2");

        // Load-use held three cycles; last cycle also has an older ready match
        load_use_setup();
        expect_val("lu0/fwd_sel", S_FWD, 32'(1) << SEL_W);
        tick("lu0");
        expect_val("lu1/fwd_sel", S_FWD, 32'(1) << SEL_W);
        tick("lu1");
        set_stage(1, 5'd7);
        bus.stage_wr = 3'b011;
        expect_val("lu_older/fwd_sel", S_FWD, 32'(1) << SEL_W);
        tick("lu_older");

        // Long-op on x9: pending, read stall, WAW + dropped issue, done still stalls
        clear_inputs();
        bus.lo_issue  = 1'b1;
        bus.dst_addr  = 5'd9;
        bus.dst_valid = 1'b1;
        expect_val("lo9_issue/pend", S_PEND, 0);
        tick("lo9_issue");
        clear_inputs();
        set_src(0, 5'd9);
        bus.src_valid = 3'b001;
        bus.dst_addr  = 5'd9;
        bus.dst_valid = 1'b1;
        bus.lo_issue  = 1'b1;
        exp_stall     = 1'b1;
        expect_val("lo9_rd/pend", S_PEND, 1);
        tick("lo9_rd");
        clear_inputs();
        set_src(0, 5'd9);
        bus.src_valid  = 3'b001;
        bus.lo_done    = 1'b1;
        bus.lo_done_rd = 5'd9;
        exp_stall      = 1'b1;
        expect_val("lo9_done/pend", S_PEND, 1);
        tick("lo9_done");
        clear_inputs();
        set_src(0, 5'd9);
        bus.src_valid = 3'b001;
        expect_val("lo9_after/pend", S_PEND, 0);
        tick("lo9_after");

        // Same-register issue and done: set wins
        clear_inputs();
        bus.lo_issue = 1'b1;
        bus.dst_addr = 5'd3;
        tick("lo3_issue");
        clear_inputs();
        bus.lo_issue   = 1'b1;
        bus.dst_addr   = 5'd3;
        bus.lo_done    = 1'b1;
        bus.lo_done_rd = 5'd3;
        expect_val("lo3_both/pend", S_PEND, 1);
        tick("lo3_both");
        clear_inputs();
        set_src(0, 5'd3);
        bus.src_valid = 3'b001;
        exp_stall     = 1'b1;
        expect_val("lo3_kept/pend", S_PEND, 1);
        tick("lo3_kept");
        clear_inputs();
        bus.lo_done    = 1'b1;
        bus.lo_done_rd = 5'd3;
        tick("lo3_done");

        // Address 0 everywhere: no forward, no stall, no pending, no error
        clear_inputs();
        bus.src_valid  = 3'b111;
        bus.stage_wr   = 3'b111;
        bus.dst_valid  = 1'b1;
        bus.lo_issue   = 1'b1;
        bus.lo_done    = 1'b1;
        expect_val("x0/fwd_sel", S_FWD, 0);
        expect_val("x0/pend", S_PEND, 0);
        tick("x0");
        clear_inputs();
        expect_val("x0_after/pend", S_PEND, 0);
        expect_val("x0_after/sb_err", S_ERR, 0);
        tick("x0_after");

        // Done for a clear register sets a sticky error
        clear_inputs();
        bus.lo_done    = 1'b1;
        bus.lo_done_rd = 5'd12;
        expect_val("err12/sb_err", S_ERR, 0);
        tick("err12");
        clear_inputs();
        expect_val("err12_set/sb_err", S_ERR, 1);
        expect_val("err12_set/pend", S_PEND, 0);
        tick("err12_set");
        expect_val("err12_hold/sb_err", S_ERR, 1);
        tick("err12_hold");

        // Saturation of the stall counter, then clear wins over increment
        load_use_setup();
        repeat ((1 << CNT_W) + 3) @(posedge clk);
        #1;
        exp_cnt = 32'hFFFF;
        tick("sat");
        bus.cnt_clr = 1'b1;
        tick("sat_clr");
        clear_inputs();
        tick("after_clr");

        // Reset mid-operation drops pending bits; the late completion is flagged
        clear_inputs();
        bus.lo_issue = 1'b1;
        bus.dst_addr = 5'd9;
        tick("mid_issue");
        clear_inputs();
        expect_val("mid_pend", S_PEND, 1);
        tick("mid_pend");
        arst_n = 1'b0;
        #2;
        arst_n  = 1'b1;
        exp_cnt = 0;
        bus.lo_done    = 1'b1;
        bus.lo_done_rd = 5'd9;
        expect_val("mid_rst/pend", S_PEND, 0);
        expect_val("mid_rst/sb_err", S_ERR, 0);
        tick("mid_rst");
        clear_inputs();
        expect_val("mid_late/sb_err", S_ERR, 1);
        expect_val("mid_late/pend", S_PEND, 0);
        tick("mid_late");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor of the pipeline forwarding unit for the RISC-V core.
- Generates per-operand bypass selects for NUM_SRC read operands across NUM_STAGES forwarding sources. Stage 0 is the youngest and has the highest priority.
- Adds a registered scoreboard for long-latency writers (mul/div), load-use and WAW stall generation, and a saturating stall-cycle counter.
- Sits beside the ID/EX boundary; drives operand muxes and the pipeline stall line.

Parameters:
- ADDR_W, 5, register address width.
- NUM_SRC, 3, number of read operands checked per cycle.
- NUM_STAGES, 3, number of forwarding source stages; index 0 is youngest.
- SEL_W, $clog2(NUM_STAGES+1), width of each select field (derived; not overridable).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  core clock.
- arst_n  in  1  asynchronous active-low reset.
- src_addr  in  NUM_SRC*ADDR_W  operand addresses; operand i occupies bits [i*ADDR_W +: ADDR_W].
- src_valid  in  NUM_SRC  operand i is actually read.
- dst_addr  in  ADDR_W  destination of the instruction in ID.
- dst_valid  in  1  instruction in ID writes a register.
- stage_rd  in  NUM_STAGES*ADDR_W  destination register held in each forwarding stage.
- stage_wr  in  NUM_STAGES  the stage will write its rd.
- stage_rdy  in  NUM_STAGES  the stage's result value is available now; 0 for a load still in EX.
- lo_issue  in  1  long-latency op issued this cycle, with destination dst_addr.
- lo_done  in  1  long-latency op completing this cycle.
- lo_done_rd  in  ADDR_W  destination of the completing op.
- cnt_clr  in  1  synchronous clear of stall_count.
- fwd_sel  out  NUM_SRC*SEL_W  select per operand: 0 = register file, k = stage k-1.
- stall  out  1  hold ID and insert a bubble.
- pend_count  out  ADDR_W+1  number of set scoreboard bits (registered).
- stall_count  out  CNT_W  saturating count of stalled cycles.
- sb_err  out  1  sticky: lo_done arrived for a register with no pending bit.

Behaviour:
- Reset (arst_n low, asynchronous):
  - scoreboard cleared;
  - pend_count=0, stall_count=0, sb_err=0.
  - fwd_sel and stall are combinational, so they evaluate to 0 with all-zero inputs.
- Address 0 handling:
  - Address 0 never matches a stage, never sets a scoreboard bit, and never stalls.
  - lo_issue or lo_done with address 0 is ignored and does not set sb_err.
- Forward match for operand i at stage k: src_valid[i] && stage_wr[k] && stage_rd[k]==src_addr[i] && src_addr[i]!=0.
- fwd_sel[i]: the lowest k that matches gives k+1; if no stage matches, 0. This is a purely combinational, zero-latency path.
- Load-use hazard: the lowest matching stage has stage_rdy[k]=0.
  - stall=1.
  - fwd_sel still shows that stage; an older ready match is never used instead.
- Scoreboard hazard:
  - Any src_valid[i] operand whose scoreboard bit is set gives stall=1.
  - dst_valid with the bit for dst_addr set gives stall=1 (WAW).
  - A bit being cleared by lo_done in the same cycle still counts as set. The scoreboard is a registered view and has no same-cycle bypass.
- stall is the OR of the load-use and scoreboard hazards.
- Scoreboard update at the clk rising edge:
  - lo_issue && !stall && dst_addr!=0 sets bit[dst_addr].
  - lo_done && lo_done_rd!=0 clears bit[lo_done_rd] if it is set. If it is not set, the scoreboard is unchanged and sb_err is set (sticky until reset).
  - Issue and done to the same register in the same cycle: the bit stays set, because the set wins. pend_count is unchanged.
  - Issue while stall=1 is dropped; the issuer re-presents it.
- pend_count tracks the scoreboard:
  - +1 on an effective set of a clear bit;
  - -1 on an effective clear;
  - net 0 for simultaneous set+clear on different registers, or for the same-register set-wins case;
  - it always equals the popcount of the scoreboard.
- stall_count:
  - cnt_clr gives 0, with priority over increment;
  - otherwise it increments by 1 each cycle stall=1;
  - it saturates at all-ones and does not wrap.
- Reset mid-operation clears all pending bits. In-flight long ops completing afterwards set sb_err; this is required behaviour.

Test Plan:
- Reset, all inputs 0 -> fwd_sel=0, stall=0, pend_count=0, stall_count=0, sb_err=0.
- src_addr[0]=5, src_valid=001, stage_rd0=5 and stage_rd1=5, stage_wr=011, stage_rdy=111 -> fwd_sel[0]=1 (youngest stage wins), stall=0; then stage_wr=010 -> fwd_sel[0]=2.
- Load-use: stage0 rd=7, stage_wr=001, stage_rdy=110, src_addr[1]=7, src_valid=010 -> stall=1, fwd_sel[1]=1, stall_count increments by 1 each cycle held.
- lo_issue, dst_addr=9, dst_valid=1 -> next cycle pend_count=1; src read of 9 -> stall=1; lo_done with lo_done_rd=9 -> stall is still 1 that cycle, 0 the next; pend_count=0.
- Same-cycle lo_issue dst=3 and lo_done rd=3 with bit 3 set -> bit 3 stays set, pend_count unchanged; lo_done rd=12 with bit 12 clear -> sb_err=1 and it stays 1.
- Force stall=1 for 2^CNT_W+3 cycles -> stall_count holds at 16'hFFFF; cnt_clr asserted together with stall=1 -> next stall_count=0. Also check address 0 everywhere -> no forward, no stall.
